// File: rtl/uart_pkg.sv
// Shared definitions for the decimal-frame UART sender.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package uart_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        LOAD    = 3'd2,
        SEND    = 3'd3,
        WAIT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // 10^n, evaluated at elaboration to derive the largest printable value.
    function automatic longint unsigned pow10(input int n);
        longint unsigned v;
        v = 1;
        for (int i = 0; i < n; i++) begin
            v = v * 10;
        end
        return v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift plus add-3, one input bit per cycle).
// Latency: start sampled on cycle t; shifts on t+1..t+DATA_W; bcd valid from t+DATA_W+1.
// Backpressure: none; caller must not restart while a conversion is running.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : load bin and begin a conversion
//   bin        : binary value to convert
//   done       : high in the cycle performing the final shift
//   bcd        : packed BCD result, digit 0 in bits [3:0]; holds until next start
module bin2bcd_seq
    import uart_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_shift;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_active;
    logic [BCD_W-1:0]  w_adj;

    // Any digit >= 5 gets +3 so the following left shift carries into the
    // next decade. Bits shifted out of the top digit are lost; the caller
    // detects values that do not fit.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign done = r_active && (r_cnt == CNT_W'(DATA_W - 1));
    assign bcd  = r_bcd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_shift  <= bin;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_bcd   <= {w_adj[BCD_W-2:0], r_shift[DATA_W-1]};
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_num_sender.sv
// Formats a binary number as a fixed-width decimal ASCII frame and feeds it to a UART TX.
// Latency: request on cycle t -> busy at t+1, first tx_start at t+DATA_W+2 (if tx_busy=0).
// Backpressure: holds in SEND while tx_busy; one extra request is queued while busy, others drop.
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   number      : binary value, captured when a request is accepted
//   send_req    : one-cycle request pulse
//   auto_en     : level enabling the periodic auto-report timer
//   tx_busy     : UART busy; a byte is only started while this is low
//   tx_done     : UART one-cycle byte-complete pulse
//   tx_start    : one-cycle byte start to the UART
//   tx_data     : byte being sent, stable from tx_start until its tx_done
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last byte completes
//   overflow    : set for a frame whose value does not fit in DIGITS digits
module uart_num_sender
    import uart_pkg::*;
#(
    parameter int DATA_W      = 14,
    parameter int DIGITS      = 4,
    parameter int SEND_CRLF   = 1,
    parameter int LEAD_ZERO   = 1,
    parameter int AUTO_PERIOD = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] number,
    input  logic              send_req,
    input  logic              auto_en,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int FRAME_LEN = DIGITS + ((SEND_CRLF != 0) ? 2 : 0);
    localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TMR_W     = $clog2(AUTO_PERIOD);
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [DATA_W-1:0]      r_num;
    logic                   r_pend;
    logic                   r_ovf;
    logic [TMR_W-1:0]       r_tmr;
    logic [IDX_W-1:0]       r_idx;
    logic [8*FRAME_LEN-1:0] r_frame;
    logic [7:0]             r_tx_data;

    logic                   w_auto_tick;
    logic                   w_req;
    logic                   w_accept;
    logic                   w_ovf;
    logic                   w_conv_done;
    logic [4*DIGITS-1:0]    w_bcd;
    logic [8*DIGITS-1:0]    w_digits;
    logic [8*FRAME_LEN-1:0] w_frame;
    logic [7:0]             w_next_byte;
    logic [3:0]             w_digit;
    logic                   w_lead;

    // ------------------------------------------------------------------
    // Request sources. A tick coinciding with send_req is one request; a
    // queued request merges with any new one arriving in the same cycle.
    // ------------------------------------------------------------------
    assign w_auto_tick = auto_en && (r_tmr == TMR_W'(AUTO_PERIOD - 1));
    assign w_req       = send_req || w_auto_tick;
    assign w_accept    = (r_state == IDLE) && (w_req || r_pend);

    always_ff @(posedge clk) begin
        if (reset || !auto_en) begin
            r_tmr <= '0;
        end else if (w_auto_tick) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + TMR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Conversion. Started by the accept itself so the number captured into
    // r_num and the value being converted are the same sample.
    // ------------------------------------------------------------------
    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (w_accept),
        .bin   (number),
        .done  (w_conv_done),
        .bcd   (w_bcd)
    );

    // The converter keeps only DIGITS decades, so overflow is judged on the
    // captured binary value rather than on the BCD result.
    assign w_ovf = 64'(r_num) > MAX_VAL;

    // Digit bytes, most significant digit in byte 0. Blanking stops at the
    // first nonzero digit and never touches the units digit.
    always_comb begin
        w_digits = '0;
        w_digit  = '0;
        w_lead   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_digit = w_bcd[4*(DIGITS-1-i) +: 4];
            if (w_ovf) begin
                w_digits[8*i +: 8] = ASCII_NINE;
            end else if ((LEAD_ZERO == 0) && w_lead && (w_digit == 4'd0) && (i != DIGITS - 1)) begin
                w_digits[8*i +: 8] = ASCII_SPACE;
            end else begin
                w_digits[8*i +: 8] = ASCII_ZERO + {4'd0, w_digit};
                w_lead             = 1'b0;
            end
        end
    end

    generate
        if (SEND_CRLF != 0) begin : g_crlf
            assign w_frame = {ASCII_LF, ASCII_CR, w_digits};
        end else begin : g_no_crlf
            assign w_frame = w_digits;
        end
    endgenerate

    // Byte following the current index, preloaded into tx_data on tx_done so
    // it is already stable when the next tx_start is raised.
    always_comb begin
        w_next_byte = '0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (k == int'(r_idx) + 1) begin
                w_next_byte = r_frame[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        tx_start   = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = CONVERT;
                end
            end
            CONVERT: begin
                if (w_conv_done) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    w_next   = WAIT;
                end
            end
            WAIT: begin
                // tx_busy is deliberately ignored here; only tx_done ends a byte.
                if (tx_done) begin
                    w_next = (r_idx == LAST_IDX) ? DONE : SEND;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num     <= '0;
            r_pend    <= 1'b0;
            r_ovf     <= 1'b0;
            r_idx     <= '0;
            r_frame   <= '0;
            r_tx_data <= '0;
        end else begin
            if (w_accept) begin
                r_num <= number;
            end

            // One-deep queue of requests seen while a frame is in flight.
            if (w_accept) begin
                r_pend <= 1'b0;
            end else if ((r_state != IDLE) && w_req) begin
                r_pend <= 1'b1;
            end

            if (r_state == LOAD) begin
                r_ovf     <= w_ovf;
                r_frame   <= w_frame;
                r_tx_data <= w_frame[7:0];
                r_idx     <= '0;
            end

            if ((r_state == WAIT) && tx_done && (r_idx != LAST_IDX)) begin
                r_idx     <= r_idx + IDX_W'(1);
                r_tx_data <= w_next_byte;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign overflow = r_ovf;
    assign tx_data  = r_tx_data;

endmodule
